// File: rtl/usb_rx_pkt_pkg.sv
// Shared USB receive constants: PID groups, CRC polynomials/residuals, PID check helper.
package usb_rx_pkt_pkg;

  localparam logic [3:0] PID_SOF = 4'h5;

  localparam logic [1:0] PIDGROUP_SPECIAL = 2'b00;
  localparam logic [1:0] PIDGROUP_TOKEN   = 2'b01;
  localparam logic [1:0] PIDGROUP_HSHK    = 2'b10;
  localparam logic [1:0] PIDGROUP_DATA    = 2'b11;

  localparam logic [4:0]  CRC5_POLY      = 5'h05;
  localparam logic [4:0]  CRC5_INIT      = 5'h1F;
  localparam logic [4:0]  CRC5_RESIDUAL  = 5'h0C;
  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

  // Upper nibble of a PID byte must be the complement of the lower nibble.
  function automatic logic pid_ok(input logic [7:0] p);
    return p[7:4] == ~p[3:0];
  endfunction

endpackage

// File: rtl/usb_crc_serial.sv
// Bit-serial CRC register, MSB-first feedback. Exposes the next value so the
// caller can check a residual in the same cycle the final bit arrives.
module usb_crc_serial #(
  parameter int               WIDTH = 5,
  parameter logic [WIDTH-1:0] POLY  = '0,
  parameter logic [WIDTH-1:0] INIT  = '1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_init,
  input  logic             i_en,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_crcNext
);

  logic [WIDTH-1:0] crc_q, crc_d;
  logic             fb;

  always_comb begin
    fb    = crc_q[WIDTH-1] ^ i_bit;
    crc_d = crc_q;
    if (i_init)    crc_d = INIT;
    else if (i_en) crc_d = {crc_q[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) crc_q <= INIT;
    else       crc_q <= crc_d;
  end

  assign o_crcNext = crc_d;

endmodule

// File: rtl/usb_rx_pkt.sv
// USB packet decoder: PID/CRC checking, token field extraction and DATA payload
// streaming with the trailing CRC16 bytes held back in a 2-deep pipe.
module usb_rx_pkt
  import usb_rx_pkt_pkg::*;
#(
  parameter int MAX_DATA_BYTES = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pktStart,
  input  logic        i_bitStrobe,
  input  logic        i_bit,
  input  logic        i_bitErr,
  input  logic        i_pktEnd,
  output logic        o_rxPktBegin,
  output logic        o_rxPktEnd,
  output logic        o_rxPktValid,
  output logic [3:0]  o_rxPid,
  output logic [6:0]  o_rxAddr,
  output logic [3:0]  o_rxEndp,
  output logic [10:0] o_rxFrameNum,
  output logic        o_rxDataPut,
  output logic [7:0]  o_rxData
);

  localparam logic [5:0] ST_IDLE  = 6'b000001;
  localparam logic [5:0] ST_PID   = 6'b000010;
  localparam logic [5:0] ST_TOKEN = 6'b000100;
  localparam logic [5:0] ST_DATA  = 6'b001000;
  localparam logic [5:0] ST_HSHK  = 6'b010000;
  localparam logic [5:0] ST_SINK  = 6'b100000;
  localparam logic [7:0] MAX_BYTES = 8'(MAX_DATA_BYTES + 2);

  logic [5:0]  state_q, state_d, stAfter;
  logic [2:0]  bitCnt_q, bitCnt_d;
  logic [7:0]  byteCnt_q, byteCnt_d;
  logic [15:0] sr_q, sr_d;
  logic        err_q, err_d;
  logic [7:0]  hold0_q, hold0_d, hold1_q, hold1_d;
  logic [1:0]  holdCnt_q, holdCnt_d;

  logic        begin_q, begin_d, end_q, end_d, valid_q, valid_d, put_q, put_d;
  logic [3:0]  pid_q, pid_d, endp_q, endp_d;
  logic [6:0]  addr_q, addr_d;
  logic [10:0] frame_q, frame_d;
  logic [7:0]  data_q, data_d;

  logic        inPkt, bitIn, byteDone, pidDone, putTry, overflow, putOk, endEv, typeOk;
  logic [7:0]  curByte;
  logic [4:0]  crc5Next;
  logic [15:0] crc16Next;

  // A start strobe owns the cycle: any coincident bit belongs to the old packet and is dropped.
  assign inPkt    = (state_q != ST_IDLE);
  assign bitIn    = i_bitStrobe && inPkt && !i_pktStart;
  assign byteDone = bitIn && (bitCnt_q == 3'd7);
  assign pidDone  = byteDone && (state_q == ST_PID);
  assign curByte  = sr_d[15:8];
  assign putTry   = byteDone && (state_q == ST_DATA) && (holdCnt_q == 2'd2);
  assign overflow = putTry && (byteCnt_q >= MAX_BYTES);
  assign putOk    = putTry && !overflow && !err_q && !i_bitErr;
  assign endEv    = i_pktEnd && inPkt && !i_pktStart;

  usb_crc_serial #(.WIDTH(5), .POLY(CRC5_POLY), .INIT(CRC5_INIT)) u_crc5 (
    .i_clk(i_clk), .i_rst(i_rst), .i_init(pidDone),
    .i_en(bitIn && (state_q == ST_TOKEN)), .i_bit(i_bit), .o_crcNext(crc5Next)
  );

  usb_crc_serial #(.WIDTH(16), .POLY(CRC16_POLY), .INIT(CRC16_INIT)) u_crc16 (
    .i_clk(i_clk), .i_rst(i_rst), .i_init(pidDone),
    .i_en(bitIn && (state_q == ST_DATA)), .i_bit(i_bit), .o_crcNext(crc16Next)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      bitCnt_q  <= '0;
      byteCnt_q <= '0;
      sr_q      <= '0;
      err_q     <= 1'b0;
      hold0_q   <= '0;
      hold1_q   <= '0;
      holdCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bitCnt_q  <= bitCnt_d;
      byteCnt_q <= byteCnt_d;
      sr_q      <= sr_d;
      err_q     <= err_d;
      hold0_q   <= hold0_d;
      hold1_q   <= hold1_d;
      holdCnt_q <= holdCnt_d;
    end
  end

  always_comb begin
    sr_d      = bitIn ? {i_bit, sr_q[15:1]} : sr_q;
    bitCnt_d  = bitCnt_q + 3'(bitIn);
    byteCnt_d = byteCnt_q;
    if (pidDone)                                byteCnt_d = '0;
    else if (byteDone && byteCnt_q != 8'hFF)    byteCnt_d = byteCnt_q + 8'd1;

    stAfter = state_q;
    if (pidDone) begin
      if (!pid_ok(curByte)) stAfter = ST_SINK;
      else begin
        case (curByte[1:0])
          PIDGROUP_TOKEN: stAfter = ST_TOKEN;
          PIDGROUP_DATA:  stAfter = ST_DATA;
          PIDGROUP_HSHK:  stAfter = ST_HSHK;
          default:        stAfter = ST_SINK;
        endcase
      end
    end

    err_d = err_q | (inPkt & i_bitErr) | (pidDone & (stAfter == ST_SINK))
          | (bitIn & (state_q == ST_HSHK)) | overflow;

    hold0_d   = hold0_q;
    hold1_d   = hold1_q;
    holdCnt_d = holdCnt_q;
    if (byteDone && state_q == ST_DATA) begin
      hold1_d = hold0_q;
      hold0_d = curByte;
      if (holdCnt_q != 2'd2) holdCnt_d = holdCnt_q + 2'd1;
    end

    state_d = endEv ? ST_IDLE : stAfter;
    if (i_pktStart) begin
      state_d   = ST_PID;
      bitCnt_d  = '0;
      byteCnt_d = '0;
      err_d     = 1'b0;
      holdCnt_d = '0;
    end
  end

  always_comb begin
    case (stAfter)
      ST_TOKEN: typeOk = (bitCnt_d == 3'd0) && (byteCnt_d == 8'd2) && (crc5Next == CRC5_RESIDUAL);
      ST_DATA:  typeOk = (bitCnt_d == 3'd0) && (byteCnt_d >= 8'd2) && (crc16Next == CRC16_RESIDUAL);
      ST_HSHK:  typeOk = (bitCnt_d == 3'd0) && (byteCnt_d == 8'd0);
      default:  typeOk = 1'b0;
    endcase

    begin_d = i_pktStart;
    end_d   = endEv || (i_pktStart && inPkt);
    valid_d = endEv && !err_d && typeOk;
    pid_d   = pidDone ? curByte[3:0] : pid_q;
    addr_d  = addr_q;
    endp_d  = endp_q;
    if (byteDone && state_q == ST_TOKEN && byteCnt_q == 8'd1 && pid_q != PID_SOF) begin
      addr_d = sr_d[6:0];
      endp_d = sr_d[10:7];
    end
    frame_d = (valid_d && stAfter == ST_TOKEN && pid_q == PID_SOF) ? sr_d[10:0] : frame_q;
    put_d   = putOk;
    data_d  = putOk ? hold1_q : data_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      begin_q <= 1'b0;
      end_q   <= 1'b0;
      valid_q <= 1'b0;
      pid_q   <= '0;
      addr_q  <= '0;
      endp_q  <= '0;
      frame_q <= '0;
      put_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      begin_q <= begin_d;
      end_q   <= end_d;
      valid_q <= valid_d;
      pid_q   <= pid_d;
      addr_q  <= addr_d;
      endp_q  <= endp_d;
      frame_q <= frame_d;
      put_q   <= put_d;
      data_q  <= data_d;
    end
  end

  assign o_rxPktBegin = begin_q;
  assign o_rxPktEnd   = end_q;
  assign o_rxPktValid = valid_q;
  assign o_rxPid      = pid_q;
  assign o_rxAddr     = addr_q;
  assign o_rxEndp     = endp_q;
  assign o_rxFrameNum = frame_q;
  assign o_rxDataPut  = put_q;
  assign o_rxData     = data_q;

endmodule
